// File: rtl/lh_pkg.sv
// Shared constants, state encoding and byte helpers for the light-hash round scheduler.
package lh_pkg;

   localparam logic [7:0] HEAD_BYTE = 8'hFF;
   localparam logic [7:0] TAIL_BYTE = 8'h00;
   localparam logic [7:0] LO1_BYTE  = 8'h20;
   localparam logic [7:0] HI1_BYTE  = 8'h7E;
   localparam logic [7:0] LO2_BYTE  = 8'hA1;
   localparam logic [7:0] HI2_BYTE  = 8'hFE;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BYTE = 2'd1,
      ROUND     = 2'd2
   } lh_state_t;

   // True only for payload characters; head and tail are classified separately.
   function automatic logic is_legal_byte(input logic [7:0] b);
      return ((b >= LO1_BYTE) && (b <= HI1_BYTE)) || ((b >= LO2_BYTE) && (b <= HI2_BYTE));
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] n);
      logic [15:0] t;
      t = {x, x} << n;
      return t[15:8];
   endfunction

endpackage

// File: rtl/lh_sbox.sv
// Combinational AES forward S-box; one instance is shared across all digest lanes.
module lh_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign y = SBOX[a];

endmodule

// File: rtl/lh_round_scheduler.sv
// Framed byte-stream hash controller: one S-box lookup per cycle, eight lanes per round.
//   state     | meaning
//   IDLE      | no frame open, waiting for head byte
//   WAIT_BYTE | frame open, waiting for payload, tail or restart
//   ROUND     | running update rounds for the latched payload byte
module lh_round_scheduler
   import lh_pkg::*;
#(
   parameter int          ROUNDS      = 32,
   parameter logic [63:0] INIT_DIGEST = 64'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  msg_byte,
   input  logic        msg_valid,
   output logic        msg_ready,
   output logic [63:0] digest,
   output logic        digest_ready,
   output logic        err_invalid_message_byte,
   output logic        busy
);

   localparam logic [5:0] ROUND_LAST = 6'(ROUNDS - 1);

   lh_state_t   state_q, state_d;
   logic [7:0]  h_q [8];
   logic [7:0]  n_q [8];
   logic [7:0]  m_q;
   logic [2:0]  lane_q;
   logic [5:0]  round_q;
   logic [63:0] digest_q;
   logic        digest_ready_q;
   logic        err_q;

   logic        accept, is_head, is_tail, is_payload, is_illegal;
   logic        lane_last, round_last;
   logic [7:0]  sbox_in, sbox_out;
   logic [63:0] h_flat;

   assign accept     = msg_valid && msg_ready;
   assign is_head    = (msg_byte == HEAD_BYTE);
   assign is_tail    = (msg_byte == TAIL_BYTE);
   assign is_payload = is_legal_byte(msg_byte);
   assign is_illegal = !is_head && !is_tail && !is_payload;
   assign lane_last  = (lane_q == 3'd7);
   assign round_last = (round_q == ROUND_LAST);

   // 3-bit add wraps the lane source index mod 8.
   assign sbox_in = rotl8(h_q[lane_q + 3'd2] ^ m_q, lane_q);

   lh_sbox u_sbox (
      .a (sbox_in),
      .y (sbox_out)
   );

   always_comb begin
      h_flat = '0;
      for (int i = 0; i < 8; i++) h_flat[63 - 8*i -: 8] = h_q[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept && is_head) state_d = WAIT_BYTE;
         end
         WAIT_BYTE: begin
            if (accept) begin
               if (is_payload)   state_d = ROUND;
               else if (is_head) state_d = WAIT_BYTE;
               else              state_d = IDLE;
            end
         end
         ROUND: begin
            if (lane_last && round_last) state_d = WAIT_BYTE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Ready is gated by rst_n so the source sees no acceptance while held in reset.
   always_comb begin
      msg_ready = rst_n && (state_q != ROUND);
      busy      = (state_q != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            h_q[i] <= INIT_DIGEST[63 - 8*i -: 8];
            n_q[i] <= 8'h00;
         end
         m_q            <= 8'h00;
         lane_q         <= 3'd0;
         round_q        <= 6'd0;
         digest_q       <= 64'h0;
         digest_ready_q <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept && (is_head || is_illegal)) begin
                  for (int i = 0; i < 8; i++) h_q[i] <= INIT_DIGEST[63 - 8*i -: 8];
                  digest_q       <= 64'h0;
                  digest_ready_q <= 1'b0;
                  err_q          <= is_illegal;
               end
            end
            WAIT_BYTE: begin
               if (accept) begin
                  if (is_payload) begin
                     m_q     <= msg_byte;
                     lane_q  <= 3'd0;
                     round_q <= 6'd0;
                  end else if (is_tail) begin
                     digest_q       <= h_flat;
                     digest_ready_q <= 1'b1;
                  end else begin
                     for (int i = 0; i < 8; i++) h_q[i] <= INIT_DIGEST[63 - 8*i -: 8];
                     if (is_illegal) begin
                        err_q          <= 1'b1;
                        digest_q       <= 64'h0;
                        digest_ready_q <= 1'b0;
                     end
                  end
               end
            end
            ROUND: begin
               n_q[lane_q] <= sbox_out;
               lane_q      <= lane_q + 3'd1;
               // Lane 7's result is still on the S-box output, so commit it directly.
               if (lane_last) begin
                  for (int i = 0; i < 7; i++) h_q[i] <= n_q[i];
                  h_q[7]  <= sbox_out;
                  round_q <= round_q + 6'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign digest                   = digest_q;
   assign digest_ready             = digest_ready_q;
   assign err_invalid_message_byte = err_q;

endmodule

// File: tb/tb_lh_round_scheduler.sv
// Directed bench for lh_round_scheduler: frame vector table plus hand-written reset/error sequences.
module tb_lh_round_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   always #5 clk = ~clk;

   logic [7:0]  byte_a, byte_b;
   logic        valid_a, valid_b;
   logic        ready_a, ready_b;
   logic [63:0] digest_a, digest_b;
   logic        dr_a, dr_b, err_a, err_b, busy_a, busy_b;

   lh_round_scheduler dut_a (
      .clk(clk), .rst_n(rst_n), .msg_byte(byte_a), .msg_valid(valid_a), .msg_ready(ready_a),
      .digest(digest_a), .digest_ready(dr_a), .err_invalid_message_byte(err_a), .busy(busy_a)
   );

   lh_round_scheduler #(.ROUNDS(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .msg_byte(byte_b), .msg_valid(valid_b), .msg_ready(ready_b),
      .digest(digest_b), .digest_ready(dr_b), .err_invalid_message_byte(err_b), .busy(busy_b)
   );

   int          sel;
   logic        cur_ready, cur_dr, cur_err, cur_busy;
   logic [63:0] cur_digest;
   always_comb begin
      cur_ready  = (sel != 0) ? ready_b  : ready_a;
      cur_dr     = (sel != 0) ? dr_b     : dr_a;
      cur_err    = (sel != 0) ? err_b    : err_a;
      cur_busy   = (sel != 0) ? busy_b   : busy_a;
      cur_digest = (sel != 0) ? digest_b : digest_a;
   end

   int errors = 0;
   int checks = 0;
   int errp_a = 0;
   int errp_b = 0;
   always @(negedge clk) begin
      if (err_a === 1'b1) errp_a++;
      if (err_b === 1'b1) errp_b++;
   end

   logic [7:0] sb [256];

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      logic       hi;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = a << 1;
         if (hi) a = a ^ 8'h1b;
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] x, input int j);
      logic [7:0] r;
      r = (x << j) | (x >> (8 - j));
      return r;
   endfunction

   function automatic logic [7:0] sbox_calc(input logic [7:0] x);
      logic [7:0] inv;
      inv = 8'h01;
      if (x == 8'h00) inv = 8'h00;
      else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      return inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [63:0] model_byte(input int rounds, input logic [63:0] hin, input logic [7:0] m);
      logic [7:0]  h [8];
      logic [7:0]  n [8];
      logic [63:0] r;
      for (int i = 0; i < 8; i++) h[i] = hin[63 - 8*i -: 8];
      for (int k = 0; k < rounds; k++) begin
         for (int j = 0; j < 8; j++) n[j] = sb[rl(h[(j + 2) % 8] ^ m, j)];
         for (int j = 0; j < 8; j++) h[j] = n[j];
      end
      r = '0;
      for (int i = 0; i < 8; i++) r[63 - 8*i -: 8] = h[i];
      return r;
   endfunction

   function automatic bit tb_payload(input logic [7:0] b);
      return (b >= 8'h20 && b <= 8'h7E) || (b >= 8'hA1 && b <= 8'hFE);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic [7:0] b, input logic v);
      if (sel != 0) begin byte_b = b; valid_b = v; end
      else          begin byte_a = b; valid_a = v; end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok = 0;
      set_in(b, 1'b1);
      for (int i = 0; i < 2000; i++) begin
         if (cur_ready) begin
            @(posedge clk); #1;
            ok = 1;
            break;
         end
         @(posedge clk); #1;
      end
      set_in(8'h00, 1'b0);
      if (!ok) check("send_timeout", 64'(b), 64'hFFFF);
   endtask

   task automatic wait_ready(output int cnt);
      cnt = 0;
      while (!cur_ready && cnt < 20000) begin
         @(posedge clk); #1;
         cnt++;
      end
   endtask

   typedef struct {
      int              sel;
      int              n;
      logic [0:5][7:0] b;
      logic [63:0]     exp_digest;
      logic            exp_dr;
      int              exp_err;
   } vec_t;

   vec_t vecs [11];

   initial begin
      int          cnt, rounds, e0, errs;
      bit          open;
      logic [63:0] h;

      rst_n = 1'b0; sel = 0;
      byte_a = 8'h00; valid_a = 1'b0; byte_b = 8'h00; valid_b = 1'b0;
      for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 64'(ready_a), 64'd0);
      check("rst_busy", 64'(busy_a), 64'd0);
      check("rst_digest", digest_a, 64'h0);
      check("rst_dr", 64'(dr_a), 64'd0);
      check("rst_err", 64'(err_a), 64'd0);
      #1 rst_n = 1'b1;
      #1 check("rel_ready", 64'(ready_a), 64'd1);
      @(posedge clk); #1;

      vecs[0]  = '{0, 2, {8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 64'h0, 1'b1, 0};
      vecs[1]  = '{1, 3, {8'hFF, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00}, 64'hB709CD7C77F230CA, 1'b1, 0};
      vecs[2]  = '{0, 3, {8'hFF, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00}, model_byte(32, 64'h0, 8'h41), 1'b1, 0};
      vecs[3]  = '{0, 2, {8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, model_byte(32, 64'h0, 8'h41), 1'b1, 0};
      vecs[4]  = '{0, 3, {8'hFF, 8'h41, 8'h05, 8'h00, 8'h00, 8'h00}, 64'h0, 1'b0, 1};
      vecs[5]  = '{0, 4, {8'hFF, 8'h41, 8'hFF, 8'h00, 8'h00, 8'h00}, 64'h0, 1'b1, 0};
      vecs[6]  = '{1, 4, {8'hFF, 8'h20, 8'h41, 8'h00, 8'h00, 8'h00},
                   model_byte(1, model_byte(1, 64'h0, 8'h20), 8'h41), 1'b1, 0};
      vecs[7]  = '{0, 4, {8'hFF, 8'h41, 8'h42, 8'h00, 8'h00, 8'h00},
                   model_byte(32, model_byte(32, 64'h0, 8'h41), 8'h42), 1'b1, 0};
      h = model_byte(1, model_byte(1, model_byte(1, model_byte(1, 64'h0, 8'hA1), 8'hFE), 8'h7E), 8'h20);
      vecs[8]  = '{1, 6, {8'hFF, 8'hA1, 8'hFE, 8'h7E, 8'h20, 8'h00}, h, 1'b1, 0};
      vecs[9]  = '{1, 1, {8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 64'h0, 1'b0, 1};
      vecs[10] = '{1, 4, {8'hFF, 8'h20, 8'hA0, 8'h1F, 8'h00, 8'h00}, 64'h0, 1'b0, 2};

      foreach (vecs[vi]) begin
         sel    = vecs[vi].sel;
         rounds = (sel != 0) ? 1 : 32;
         e0     = (sel != 0) ? errp_b : errp_a;
         open   = 0;
         for (int k = 0; k < vecs[vi].n; k++) begin
            send_byte(vecs[vi].b[k]);
            if (vecs[vi].b[k] == 8'hFF) open = 1;
            else if (open && tb_payload(vecs[vi].b[k])) begin
               wait_ready(cnt);
               check($sformatf("vec%0d_busy_cycles_b%0d", vi, k), 64'(cnt), 64'(8 * rounds));
            end else open = 0;
         end
         @(posedge clk); #1;
         errs = ((sel != 0) ? errp_b : errp_a) - e0;
         check($sformatf("vec%0d_digest", vi), cur_digest, vecs[vi].exp_digest);
         check($sformatf("vec%0d_digest_ready", vi), 64'(cur_dr), 64'(vecs[vi].exp_dr));
         check($sformatf("vec%0d_err_pulses", vi), 64'(errs), 64'(vecs[vi].exp_err));
         check($sformatf("vec%0d_busy", vi), 64'(cur_busy), 64'd0);
      end

      // Error pulse width, then a payload byte in IDLE must be dropped.
      sel = 0;
      send_byte(8'hFF);
      send_byte(8'h41);
      wait_ready(cnt);
      send_byte(8'h05);
      check("err_pulse_hi", 64'(err_a), 64'd1);
      check("err_state_idle", 64'(busy_a), 64'd0);
      @(posedge clk); #1;
      check("err_pulse_lo", 64'(err_a), 64'd0);
      send_byte(8'h41);
      check("drop_ready", 64'(ready_a), 64'd1);
      check("drop_busy", 64'(busy_a), 64'd0);
      @(posedge clk); #1;
      check("drop_err", 64'(err_a), 64'd0);
      check("drop_digest", digest_a, 64'h0);

      // Reset in the middle of ROUND, then a clean frame.
      send_byte(8'hFF);
      send_byte(8'h20);
      repeat (20) @(posedge clk);
      #1;
      check("mid_round_ready", 64'(ready_a), 64'd0);
      rst_n = 1'b0;
      #1;
      check("mr_rst_ready", 64'(ready_a), 64'd0);
      check("mr_rst_busy", 64'(busy_a), 64'd0);
      check("mr_rst_digest", digest_a, 64'h0);
      check("mr_rst_dr", 64'(dr_a), 64'd0);
      check("mr_rst_err", 64'(err_a), 64'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      #1 check("mr_rel_ready", 64'(ready_a), 64'd1);
      @(posedge clk); #1;
      send_byte(8'hFF);
      send_byte(8'h20);
      wait_ready(cnt);
      check("mr_busy_cycles", 64'(cnt), 64'd256);
      send_byte(8'h00);
      check("mr_digest", digest_a, model_byte(32, 64'h0, 8'h20));
      check("mr_dr", 64'(dr_a), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
